// File: rtl/nanov_serial_alu_if.sv
// nanov_serial_alu_if
// Bundles the request/response signals of the digit-serial nanoV ALU so the
// producer (decode/register read) and consumer (ALU) share one connection.
//   master : drives start/op/a/b and observes busy/done/result/flags
//   slave  : the ALU side
// Ports (signals):
//   start  1      request, accepted when busy is low
//   op     4      {funct7[5], funct3}
//   a, b   WIDTH  operands, sampled on accept
//   busy   1      digits in flight
//   done   1      one-cycle completion pulse
//   result WIDTH  result, held until the next accepted start
//   eq/lt/ltu 1   compare flags (SUB/SLT/SLTU only)
interface nanov_serial_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             eq;
    logic             lt;
    logic             ltu;

    modport master (
        output start, op, a, b,
        input  busy, done, result, eq, lt, ltu
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, eq, lt, ltu
    );
endinterface

// File: rtl/nanov_serial_alu.sv
// nanov_serial_alu
// Digit-serial RV32I execute unit. Operands are captured on an accepted start,
// then DIGIT result bits are produced per clock, LSB digit first, shifted into
// the result register from the MSB end. A one-cycle done pulse marks the end.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset (aborts any operation in flight)
//   alu  : nanov_serial_alu_if slave modport (start/op/a/b in,
//          busy/done/result/eq/lt/ltu out, all outputs registered)
module nanov_serial_alu #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    nanov_serial_alu_if.slave     alu
);
    localparam int SHW = $clog2(WIDTH);
    localparam int N   = WIDTH / DIGIT;
    localparam int KW  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // SUB, SLT and SLTU run the subtractor and report compare flags.
    function automatic logic is_cmp_op(input logic [3:0] o);
        return ((o[2:0] == 3'b000) && o[3]) || (o[2:0] == 3'b010) || (o[2:0] == 3'b011);
    endfunction

    state_t           state_r;
    logic [KW-1:0]    k_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic             eq_acc_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             eq_r;
    logic             lt_r;
    logic             ltu_r;

    logic [SHW-1:0]     shamt_s;
    logic [WIDTH-1:0]   a_load_s;
    logic               is_cmp_s;
    logic [DIGIT-1:0]   a_d_s;
    logic [DIGIT-1:0]   b_d_s;
    logic [DIGIT-1:0]   b_add_s;
    logic [DIGIT:0]     sum_s;
    logic [DIGIT-1:0]   digit_s;
    logic               eq_next_s;
    logic               lt_flag_s;
    logic               ltu_flag_s;
    logic               last_s;
    logic [WIDTH+DIGIT-1:0] result_cat_s;

    // Shift ops pre-align operand A at accept time, so the serial pass only
    // ever streams the low digit of the operand shift registers.
    always_comb begin
        shamt_s  = alu.b[SHW-1:0];
        a_load_s = alu.a;
        case (alu.op[2:0])
            3'b001:  a_load_s = alu.a << shamt_s;
            3'b101: begin
                if (alu.op[3]) begin
                    a_load_s = $unsigned($signed(alu.a) >>> shamt_s);
                end else begin
                    a_load_s = alu.a >> shamt_s;
                end
            end
            default: a_load_s = alu.a;
        endcase
    end

    // Per-digit datapath: adder/subtractor slice, logic ops, compare terms.
    always_comb begin
        is_cmp_s   = is_cmp_op(op_r);
        a_d_s      = a_sh_r[DIGIT-1:0];
        b_d_s      = b_sh_r[DIGIT-1:0];
        b_add_s    = is_cmp_s ? ~b_d_s : b_d_s;
        sum_s      = {1'b0, a_d_s} + {1'b0, b_add_s} + {{DIGIT{1'b0}}, carry_r};
        eq_next_s  = eq_acc_r & (a_d_s == b_d_s);
        // Differing sign bits decide signed order directly; otherwise the
        // difference's sign does (no overflow is possible then).
        lt_flag_s  = (a_d_s[DIGIT-1] != b_d_s[DIGIT-1]) ? a_d_s[DIGIT-1] : sum_s[DIGIT-1];
        ltu_flag_s = ~sum_s[DIGIT];
        last_s     = (k_r == KW'(N - 1));
        case (op_r[2:0])
            3'b000:  digit_s = sum_s[DIGIT-1:0];
            3'b001:  digit_s = a_d_s;
            3'b010:  digit_s = {DIGIT{1'b0}};
            3'b011:  digit_s = {DIGIT{1'b0}};
            3'b100:  digit_s = a_d_s ^ b_d_s;
            3'b101:  digit_s = a_d_s;
            3'b110:  digit_s = a_d_s | b_d_s;
            3'b111:  digit_s = a_d_s & b_d_s;
            default: digit_s = {DIGIT{1'b0}};
        endcase
        // New digit enters at the MSB end while the rest moves right.
        result_cat_s = {digit_s, result_r};
    end

    // Sequencer, operand shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            k_r      <= {KW{1'b0}};
            op_r     <= 4'd0;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            eq_acc_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            eq_r     <= 1'b0;
            lt_r     <= 1'b0;
            ltu_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (alu.start) begin
                        op_r     <= alu.op;
                        a_sh_r   <= a_load_s;
                        b_sh_r   <= alu.b;
                        carry_r  <= is_cmp_op(alu.op);
                        eq_acc_r <= 1'b1;
                        k_r      <= {KW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    result_r <= result_cat_s[WIDTH+DIGIT-1:DIGIT];
                    a_sh_r   <= a_sh_r >> DIGIT;
                    b_sh_r   <= b_sh_r >> DIGIT;
                    carry_r  <= sum_s[DIGIT];
                    eq_acc_r <= eq_next_s;
                    k_r      <= k_r + KW'(1);
                    if (last_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        k_r     <= {KW{1'b0}};
                        if (is_cmp_s) begin
                            eq_r  <= eq_next_s;
                            lt_r  <= lt_flag_s;
                            ltu_r <= ltu_flag_s;
                        end else begin
                            eq_r  <= 1'b0;
                            lt_r  <= 1'b0;
                            ltu_r <= 1'b0;
                        end
                        // SLT/SLTU streamed zeros; bit 0 becomes the flag.
                        if (op_r[2:0] == 3'b010) begin
                            result_r <= {{(WIDTH-1){1'b0}}, lt_flag_s};
                        end else if (op_r[2:0] == 3'b011) begin
                            result_r <= {{(WIDTH-1){1'b0}}, ltu_flag_s};
                        end else begin
                            result_r <= result_cat_s[WIDTH+DIGIT-1:DIGIT];
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign alu.busy   = busy_r;
    assign alu.done   = done_r;
    assign alu.result = result_r;
    assign alu.eq     = eq_r;
    assign alu.lt     = lt_r;
    assign alu.ltu    = ltu_r;
endmodule
